ysyx_23060077_riscv_ctrl_fsm: RTL and testbench

Multi-cycle sequencing controller for the single-issue RISC-V core: steps each instruction through fetch, decode, execute, memory and writeback. It drives the IFU/LSU request handshakes, the instruction-register, register-file and PC write enables, and a response timeout watchdog. It consumes the decoder's `lsu_opt`, illegal and rd-write flags, and sits between the IFU, the ID decode logic, the EXU and the LSU.

---
 rtl/ysyx_23060077_riscv_ctrl_fsm_pkg.sv | 69 ++++++
 rtl/ysyx_23060077_riscv_wdt.sv | 29 ++
 rtl/ysyx_23060077_riscv_ctrl_fsm.sv | 150 +++++++++++++++
 tb/tb_ysyx_23060077_riscv_ctrl_fsm.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060077_riscv_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle sequencing controller: memory classes,
// state codes, trap causes and the registered control-output bundle.
package ysyx_23060077_riscv_ctrl_fsm_pkg;

   localparam int unsigned LSU_OPT_WIDTH = 2;
   localparam int unsigned STATE_WIDTH   = 3;
   localparam int unsigned CAUSE_WIDTH   = 3;
   localparam int unsigned INSTRET_WIDTH = 64;

   localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_NONE  = 2'd0;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_LOAD  = 2'd1;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_STORE = 2'd2;
   localparam logic [LSU_OPT_WIDTH-1:0] LSU_OPT_SYS   = 2'd3;

   localparam logic [STATE_WIDTH-1:0] ST_RESET  = 3'd0;
   localparam logic [STATE_WIDTH-1:0] ST_FETCH  = 3'd1;
   localparam logic [STATE_WIDTH-1:0] ST_DECODE = 3'd2;
   localparam logic [STATE_WIDTH-1:0] ST_EXEC   = 3'd3;
   localparam logic [STATE_WIDTH-1:0] ST_MEM    = 3'd4;
   localparam logic [STATE_WIDTH-1:0] ST_WB     = 3'd5;
   localparam logic [STATE_WIDTH-1:0] ST_TRAP   = 3'd6;
   localparam logic [STATE_WIDTH-1:0] ST_HALT   = 3'd7;

   localparam logic [CAUSE_WIDTH-1:0] CAUSE_NONE    = 3'd0;
   localparam logic [CAUSE_WIDTH-1:0] CAUSE_FETCH   = 3'd1;
   localparam logic [CAUSE_WIDTH-1:0] CAUSE_ILLEGAL = 3'd2;
   localparam logic [CAUSE_WIDTH-1:0] CAUSE_LSU     = 3'd3;
   localparam logic [CAUSE_WIDTH-1:0] CAUSE_TIMEOUT = 3'd4;

   typedef struct packed {
      logic                   ifu_req;
      logic                   lsu_req;
      logic                   rf_we;
      logic                   pc_we;
      logic                   csr_en;
      logic                   trap;
      logic                   halted;
      logic [CAUSE_WIDTH-1:0] trap_cause;
   } ctrl_out_t;

   // Moore decode of the state the controller is about to occupy.
   function automatic ctrl_out_t decode_outputs(
      input logic [STATE_WIDTH-1:0]   st,
      input logic [LSU_OPT_WIDTH-1:0] opt,
      input logic                     rd_wen,
      input logic [CAUSE_WIDTH-1:0]   cause
   );
      ctrl_out_t o;
      o = '0;
      case (st)
         ST_FETCH:  o.ifu_req = 1'b1;
         ST_MEM:    o.lsu_req = 1'b1;
         ST_EXEC:   o.csr_en  = (opt == LSU_OPT_SYS);
         ST_WB: begin
            o.pc_we = 1'b1;
            o.rf_we = rd_wen && (opt != LSU_OPT_STORE);
         end
         ST_TRAP: begin
            o.trap       = 1'b1;
            o.pc_we      = 1'b1;
            o.trap_cause = cause;
         end
         ST_HALT:   o.halted  = 1'b1;
         default:   o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/ysyx_23060077_riscv_wdt.sv
// Response watchdog: counts waiting cycles and flags expiry on the last
// permitted cycle so the controller can trap on the following edge.
module ysyx_23060077_riscv_wdt #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   logic [CNT_W-1:0] r_cnt;

   assign o_expire_c = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expire_c) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ysyx_23060077_riscv_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with trap,
// halt and response-timeout handling for the single-issue core.
module ysyx_23060077_riscv_ctrl_fsm
   import ysyx_23060077_riscv_ctrl_fsm_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     o_ifu_req,
   input  logic                     i_ifu_rvalid,
   input  logic                     i_ifu_rerr,
   output logic                     o_inst_en,
   input  logic [LSU_OPT_WIDTH-1:0] i_lsu_opt,
   input  logic                     i_id_illegal,
   input  logic                     i_id_rd_wen,
   output logic                     o_lsu_req,
   input  logic                     i_lsu_rvalid,
   input  logic                     i_lsu_rerr,
   output logic                     o_rf_we,
   output logic                     o_pc_we,
   output logic                     o_csr_en,
   output logic                     o_trap,
   output logic [CAUSE_WIDTH-1:0]   o_trap_cause,
   input  logic                     i_halt_req,
   output logic                     o_halted,
   output logic [INSTRET_WIDTH-1:0] o_instret
);

   logic [STATE_WIDTH-1:0]   r_state;
   logic [STATE_WIDTH-1:0]   w_state_nxt;
   logic [LSU_OPT_WIDTH-1:0] r_opt;
   logic [LSU_OPT_WIDTH-1:0] w_opt_nxt;
   logic                     r_rd_wen;
   logic                     w_rd_wen_nxt;
   logic [CAUSE_WIDTH-1:0]   w_cause_nxt;
   ctrl_out_t                r_out;
   ctrl_out_t                w_out_nxt;
   logic [INSTRET_WIDTH-1:0] r_instret;
   logic                     w_wait;
   logic                     w_expire;

   assign w_wait = (r_state == ST_FETCH) || (r_state == ST_MEM);

   ysyx_23060077_riscv_wdt #(
      .TIMEOUT    (TIMEOUT)
   ) u_wdt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (!w_wait),
      .i_en       (w_wait),
      .o_expire_c (w_expire)
   );

   // Next-state, decode latch and trap cause selection.
   always_comb begin
      w_state_nxt  = r_state;
      w_cause_nxt  = CAUSE_NONE;
      w_opt_nxt    = r_opt;
      w_rd_wen_nxt = r_rd_wen;
      case (r_state)
         ST_RESET: w_state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (i_ifu_rvalid) begin
               if (i_ifu_rerr) begin
                  w_state_nxt = ST_TRAP;
                  w_cause_nxt = CAUSE_FETCH;
               end else begin
                  w_state_nxt = ST_DECODE;
               end
            end else if (w_expire) begin
               w_state_nxt = ST_TRAP;
               w_cause_nxt = CAUSE_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (i_id_illegal) begin
               w_state_nxt = ST_TRAP;
               w_cause_nxt = CAUSE_ILLEGAL;
            end else begin
               w_state_nxt  = ST_EXEC;
               w_opt_nxt    = i_lsu_opt;
               w_rd_wen_nxt = i_id_rd_wen;
            end
         end
         ST_EXEC: begin
            if ((r_opt == LSU_OPT_LOAD) || (r_opt == LSU_OPT_STORE)) begin
               w_state_nxt = ST_MEM;
            end else begin
               w_state_nxt = ST_WB;
            end
         end
         ST_MEM: begin
            if (i_lsu_rvalid) begin
               if (i_lsu_rerr) begin
                  w_state_nxt = ST_TRAP;
                  w_cause_nxt = CAUSE_LSU;
               end else begin
                  w_state_nxt = ST_WB;
               end
            end else if (w_expire) begin
               w_state_nxt = ST_TRAP;
               w_cause_nxt = CAUSE_TIMEOUT;
            end
         end
         ST_WB, ST_TRAP: w_state_nxt = i_halt_req ? ST_HALT : ST_FETCH;
         ST_HALT: begin
            if (!i_halt_req) begin
               w_state_nxt = ST_FETCH;
            end
         end
         default: w_state_nxt = ST_RESET;
      endcase
   end

   // Outputs are registered from the upcoming state so they track it exactly.
   assign w_out_nxt = decode_outputs(w_state_nxt, w_opt_nxt, w_rd_wen_nxt, w_cause_nxt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_RESET;
         r_opt     <= LSU_OPT_NONE;
         r_rd_wen  <= 1'b0;
         r_out     <= '0;
         r_instret <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_opt    <= w_opt_nxt;
         r_rd_wen <= w_rd_wen_nxt;
         r_out    <= w_out_nxt;
         if (r_state == ST_WB) begin
            r_instret <= r_instret + INSTRET_WIDTH'(1);
         end
      end
   end

   // The instruction register loads in the same cycle the fetch data is valid.
   assign o_inst_en    = (r_state == ST_FETCH) && i_ifu_rvalid && !i_ifu_rerr;

   assign o_ifu_req    = r_out.ifu_req;
   assign o_lsu_req    = r_out.lsu_req;
   assign o_rf_we      = r_out.rf_we;
   assign o_pc_we      = r_out.pc_we;
   assign o_csr_en     = r_out.csr_en;
   assign o_trap       = r_out.trap;
   assign o_trap_cause = r_out.trap_cause;
   assign o_halted     = r_out.halted;
   assign o_instret    = r_instret;

endmodule

// File: tb/tb_ysyx_23060077_riscv_ctrl_fsm.sv
// Bench for the sequencing controller: per-instruction expected traces built
// from latency rules, checked every cycle, plus literal event-timing checks.
module tb_ysyx_23060077_riscv_ctrl_fsm;
   import ysyx_23060077_riscv_ctrl_fsm_pkg::*;

   localparam int unsigned TMO = 8;
   localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_SYS = 3, K_ILL = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ifu_req, ifu_rvalid = 1'b0, ifu_rerr = 1'b0, inst_en;
   logic [1:0]  lsu_opt = 2'd0;
   logic        id_illegal = 1'b0, id_rd_wen = 1'b0;
   logic        lsu_req, lsu_rvalid = 1'b0, lsu_rerr = 1'b0;
   logic        rf_we, pc_we, csr_en, trap, halted;
   logic [2:0]  trap_cause;
   logic        halt_req = 1'b0;
   logic [63:0] instret;

   always #5 clk = ~clk;

   ysyx_23060077_riscv_ctrl_fsm #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .o_ifu_req(ifu_req), .i_ifu_rvalid(ifu_rvalid), .i_ifu_rerr(ifu_rerr),
      .o_inst_en(inst_en), .i_lsu_opt(lsu_opt), .i_id_illegal(id_illegal),
      .i_id_rd_wen(id_rd_wen), .o_lsu_req(lsu_req), .i_lsu_rvalid(lsu_rvalid),
      .i_lsu_rerr(lsu_rerr), .o_rf_we(rf_we), .o_pc_we(pc_we), .o_csr_en(csr_en),
      .o_trap(trap), .o_trap_cause(trap_cause), .i_halt_req(halt_req),
      .o_halted(halted), .o_instret(instret)
   );

   typedef struct {
      bit rst_n, ifu_rvalid, ifu_rerr, lsu_rvalid, lsu_rerr, illegal, rd_wen, halt;
      logic [1:0] opt;
      int tag;
   } stim_t;

   typedef struct {
      bit chk;
      bit ifu_req, inst_en, lsu_req, rf_we, pc_we, csr_en, trap, halted;
      logic [2:0] cause;
      longint unsigned instret;
   } exp_t;

   stim_t sq[$];
   exp_t  eq[$];
   longint unsigned m_instret = 0;
   int cur_tag = 0;
   int cur_idx = -1;
   bit g_halt = 1'b0;
   bit g_noise = 1'b0;
   int total = 0;
   int bad = 0;

   int a_len[32], a_ifu[32], a_lsu[32], a_rfwe[32], a_pcwe[32], a_halted[32], a_trapn[32];
   int a_pcwe_off[32], a_trap_off[32], a_cause[32];
   longint unsigned a_ins_first[32], a_ins_last[32];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic stim_t s_idle();
      stim_t s;
      s = '{default: 0};
      s.rst_n = 1'b1;
      s.halt  = g_halt;
      s.opt   = LSU_OPT_NONE;
      return s;
   endfunction

   function automatic exp_t e_none();
      exp_t e;
      e = '{default: 0};
      e.chk = 1'b1;
      e.instret = m_instret;
      return e;
   endfunction

   function automatic logic [1:0] opt_of(input int kind);
      case (kind)
         K_LOAD:  return LSU_OPT_LOAD;
         K_STORE: return LSU_OPT_STORE;
         K_SYS:   return LSU_OPT_SYS;
         default: return LSU_OPT_NONE;
      endcase
   endfunction

   task automatic push(input stim_t s, input exp_t e);
      s.tag = cur_tag;
      sq.push_back(s);
      eq.push_back(e);
   endtask

   // Reset held for n cycles, then one released cycle still parked in RESET.
   task automatic gen_reset_tail(input int n);
      stim_t s;
      exp_t e;
      m_instret = 0;
      for (int i = 0; i < n; i++) begin
         s = s_idle(); s.rst_n = 1'b0; s.halt = 1'b0;
         e = e_none();
         push(s, e);
      end
      s = s_idle(); s.halt = 1'b0;
      push(s, e_none());
   endtask

   task automatic gen_after(input bit hlt, input int hold);
      stim_t s;
      exp_t e;
      if (hlt) begin
         for (int h = 0; h < hold; h++) begin
            s = s_idle(); s.halt = (h < hold - 1);
            e = e_none(); e.halted = 1'b1;
            push(s, e);
         end
      end
      g_halt = 1'b0;
   endtask

   task automatic gen_trap(input logic [2:0] cause, input bit hlt, input int hold);
      exp_t e;
      e = e_none(); e.trap = 1'b1; e.pc_we = 1'b1; e.cause = cause;
      push(s_idle(), e);
      gen_after(hlt, hold);
   endtask

   // One instruction: response delays in cycles; a delay >= TMO never answers.
   task automatic gen_insn(input int kind, input int idly, input int ldly, input bit rdw,
                           input int flt, input bit hlt, input int hold, input bit rst_mem);
      stim_t s;
      exp_t e;
      int nf, nm;
      g_halt = hlt;
      nf = (idly < TMO) ? idly + 1 : TMO;
      for (int c = 0; c < nf; c++) begin
         s = s_idle();
         s.ifu_rvalid = (c == idly);
         s.ifu_rerr   = (c == idly) ? (flt == 1) : g_noise;
         s.lsu_rvalid = g_noise;
         s.lsu_rerr   = g_noise;
         e = e_none(); e.ifu_req = 1'b1; e.inst_en = (c == idly) && (flt != 1);
         push(s, e);
      end
      if (idly >= TMO) begin gen_trap(3'd4, hlt, hold); return; end
      if (flt == 1) begin gen_trap(3'd1, hlt, hold); return; end
      s = s_idle();
      s.opt = opt_of(kind); s.illegal = (kind == K_ILL); s.rd_wen = rdw;
      s.ifu_rvalid = g_noise;
      push(s, e_none());
      if (kind == K_ILL) begin gen_trap(3'd2, hlt, hold); return; end
      s = s_idle();
      s.opt = ~opt_of(kind); s.rd_wen = !rdw; s.illegal = 1'b1;
      e = e_none(); e.csr_en = (kind == K_SYS);
      push(s, e);
      if (kind == K_LOAD || kind == K_STORE) begin
         nm = (ldly < TMO) ? ldly + 1 : TMO;
         for (int c = 0; c < nm; c++) begin
            s = s_idle();
            s.lsu_rvalid = (c == ldly);
            s.lsu_rerr   = (c == ldly) && (flt == 3);
            s.ifu_rvalid = g_noise;
            e = e_none(); e.lsu_req = 1'b1;
            if (rst_mem && c == 1) begin
               s.rst_n = 1'b0;
               push(s, e);
               g_halt = 1'b0;
               gen_reset_tail(1);
               return;
            end
            push(s, e);
         end
         if (ldly >= TMO) begin gen_trap(3'd4, hlt, hold); return; end
         if (flt == 3) begin gen_trap(3'd3, hlt, hold); return; end
      end
      e = e_none(); e.pc_we = 1'b1; e.rf_we = rdw && (kind != K_STORE);
      push(s_idle(), e);
      m_instret++;
      gen_after(hlt, hold);
   endtask

   task automatic apply(input stim_t s);
      rst_n      = s.rst_n;
      ifu_rvalid = s.ifu_rvalid;
      ifu_rerr   = s.ifu_rerr;
      lsu_rvalid = s.lsu_rvalid;
      lsu_rerr   = s.lsu_rerr;
      id_illegal = s.illegal;
      id_rd_wen  = s.rd_wen;
      lsu_opt    = s.opt;
      halt_req   = s.halt;
   endtask

   // Per-cycle comparison against the expected trace, plus event bookkeeping.
   always @(negedge clk) begin
      if (cur_idx >= 0 && cur_idx < eq.size()) begin
         exp_t e;
         int t;
         logic [10:0] av, ev;
         e = eq[cur_idx];
         t = sq[cur_idx].tag;
         if (e.chk) begin
            av = {ifu_req, inst_en, lsu_req, rf_we, pc_we, csr_en, trap, halted, trap_cause};
            ev = {e.ifu_req, e.inst_en, e.lsu_req, e.rf_we, e.pc_we, e.csr_en, e.trap,
                  e.halted, e.cause};
            check($sformatf("ctrl cyc=%0d tag=%0d", cur_idx, t), 64'(av), 64'(ev));
            check($sformatf("instret cyc=%0d tag=%0d", cur_idx, t), instret, e.instret);
            if (a_len[t] == 0) a_ins_first[t] = instret;
            a_ins_last[t] = instret;
            if (ifu_req === 1'b1) a_ifu[t]++;
            if (lsu_req === 1'b1) a_lsu[t]++;
            if (rf_we === 1'b1) a_rfwe[t]++;
            if (halted === 1'b1) a_halted[t]++;
            if (pc_we === 1'b1) begin
               if (a_pcwe[t] == 0) a_pcwe_off[t] = a_len[t];
               a_pcwe[t]++;
            end
            if (trap === 1'b1) begin
               if (a_trapn[t] == 0) begin
                  a_trap_off[t] = a_len[t];
                  a_cause[t] = int'(trap_cause);
               end
               a_trapn[t]++;
            end
            a_len[t]++;
         end
      end
   end

   initial begin
      stim_t s;
      for (int i = 0; i < 32; i++) begin
         a_len[i] = 0; a_ifu[i] = 0; a_lsu[i] = 0; a_rfwe[i] = 0; a_pcwe[i] = 0;
         a_halted[i] = 0; a_trapn[i] = 0; a_pcwe_off[i] = -1; a_trap_off[i] = -1;
         a_cause[i] = -1; a_ins_first[i] = 0; a_ins_last[i] = 0;
      end
      cur_tag = 0;
      s = s_idle(); s.rst_n = 1'b0;
      sq.push_back(s);
      eq.push_back('{default: 0});
      gen_reset_tail(2);
      //                kind     idly     ldly     rdw flt hlt hold rst
      cur_tag = 1;  gen_insn(K_ALU,   0,       0,       1, 0,  0,  0,  0);
      cur_tag = 2;  gen_insn(K_LOAD,  3,       2,       1, 0,  0,  0,  0);
      cur_tag = 3;  gen_insn(K_STORE, 0,       0,       1, 0,  0,  0,  0);
      cur_tag = 4;  g_noise = 1'b1;
                    gen_insn(K_SYS,   1,       0,       1, 0,  0,  0,  0);
                    g_noise = 1'b0;
      cur_tag = 5;  gen_insn(K_ILL,   0,       0,       1, 0,  0,  0,  0);
      cur_tag = 6;  gen_insn(K_LOAD,  0,       1,       1, 3,  0,  0,  0);
      cur_tag = 7;  gen_insn(K_ALU,   2,       0,       1, 1,  0,  0,  0);
      cur_tag = 8;  gen_insn(K_ALU,   int'(TMO), 0,     1, 0,  0,  0,  0);
      cur_tag = 9;  gen_insn(K_ALU,   int'(TMO) - 1, 0, 0, 0,  0,  0,  0);
      cur_tag = 10; gen_insn(K_LOAD,  0,       int'(TMO), 1, 0, 0, 0, 0);
      cur_tag = 11; gen_insn(K_LOAD,  1,       2,       1, 0,  1,  3,  0);
      cur_tag = 12; g_noise = 1'b1;
                    gen_insn(K_ALU,   0,       0,       1, 0,  0,  0,  0);
                    g_noise = 1'b0;
      cur_tag = 13; gen_insn(K_LOAD,  0,       4,       1, 0,  0,  0,  1);
      cur_tag = 14; gen_insn(K_ALU,   0,       0,       1, 0,  0,  0,  0);
      cur_tag = 15; gen_insn(K_ILL,   1,       0,       0, 0,  1,  2,  0);
      cur_tag = 16; gen_insn(K_STORE, 1,       1,       0, 0,  0,  0,  0);

      for (int i = 0; i < sq.size(); i++) begin
         @(posedge clk);
         #1;
         apply(sq[i]);
         cur_idx = i;
      end
      @(posedge clk);
      #1;
      cur_idx = -1;

      check("alu_len", 64'(a_len[1]), 64'd4);
      check("alu_ifu_cycles", 64'(a_ifu[1]), 64'd1);
      check("alu_pcwe_cycle", 64'(a_pcwe_off[1]), 64'd3);
      check("alu_rfwe", 64'(a_rfwe[1]), 64'd1);
      check("alu_instret_after", a_ins_first[2], 64'd1);
      check("load_ifu_cycles", 64'(a_ifu[2]), 64'd4);
      check("load_lsu_cycles", 64'(a_lsu[2]), 64'd3);
      check("load_rfwe", 64'(a_rfwe[2]), 64'd1);
      check("load_len", 64'(a_len[2]), 64'd10);
      check("store_rfwe", 64'(a_rfwe[3]), 64'd0);
      check("store_pcwe", 64'(a_pcwe[3]), 64'd1);
      check("ill_trap_cycle", 64'(a_trap_off[5]), 64'd2);
      check("ill_cause", 64'(a_cause[5]), 64'd2);
      check("ill_instret_kept", a_ins_last[5], 64'd4);
      check("lsu_fault_cause", 64'(a_cause[6]), 64'd3);
      check("lsu_fault_cycle", 64'(a_trap_off[6]), 64'd5);
      check("ifu_fault_cause", 64'(a_cause[7]), 64'd1);
      check("ifu_fault_cycle", 64'(a_trap_off[7]), 64'd3);
      check("wdt_trap_cycle", 64'(a_trap_off[8]), 64'd8);
      check("wdt_cause", 64'(a_cause[8]), 64'd4);
      check("wdt_late_resp_notrap", 64'(a_trapn[9]), 64'd0);
      check("lsu_wdt_cause", 64'(a_cause[10]), 64'd4);
      check("halt_cycles", 64'(a_halted[11]), 64'd3);
      check("resume_fetch_first", 64'(a_ifu[12]), 64'd1);
      check("pre_reset_instret", a_ins_first[13], 64'd7);
      check("post_reset_instret", a_ins_last[13], 64'd0);
      check("trap_halt_cycles", 64'(a_halted[15]), 64'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
